// File: rtl/bool_func_sweep_ctrl_if.sv
// Control/observe bundle between the sweep sequencer, the board control and the
// Boolean function under test.
interface bool_func_sweep_ctrl_if #(
    parameter int N_IN  = 3,
    parameter int CNT_W = 4
);
    localparam int TT_W = 2 ** N_IN;

    // start is a level request taken only while IDLE (abort low); done is a
    // one-cycle pulse; tt/tt_valid/pass/mismatch_cnt hold until the next accepted start.
    logic              start;
    logic              abort;
    logic [TT_W-1:0]   exp_tt;
    logic [N_IN-1:0]   fn_in;
    logic              fn_out;
    logic              busy;
    logic              done;
    logic [TT_W-1:0]   tt;
    logic              tt_valid;
    logic              pass;
    logic [CNT_W-1:0]  mismatch_cnt;
    logic [1:0]        state_dbg;

    modport master (
        output start, abort, exp_tt, fn_out,
        input  fn_in, busy, done, tt, tt_valid, pass, mismatch_cnt, state_dbg
    );

    modport slave (
        input  start, abort, exp_tt, fn_out,
        output fn_in, busy, done, tt, tt_valid, pass, mismatch_cnt, state_dbg
    );
endinterface

// File: rtl/bool_func_sweep_ctrl.sv
// Sweeps every input vector of a small Boolean function, samples its output after a
// settle time, and compares the measured truth table against a latched expected table.
module bool_func_sweep_ctrl #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    bool_func_sweep_ctrl_if.slave  bus
);
    localparam int TT_W = 2 ** N_IN;
    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SETTLE_LAST =
        (SETTLE_CYCLES > 0) ? SC_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // With no settle time every vector goes straight to its sample cycle.
    localparam state_e S_FIRST = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [SC_W-1:0]   cnt_q, cnt_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [TT_W-1:0]   exp_q, exp_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  mism;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            exp_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            exp_q   <= exp_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        exp_d   = exp_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (bus.start && !bus.abort) begin
                    exp_d   = bus.exp_tt;
                    tt_d    = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_FIRST;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                // An aborted sample cycle leaves the partial table untouched.
                if (bus.abort) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tt_d[idx_q] = bus.fn_out;
                    if (idx_q == IDX_LAST) begin
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = '0;
                        state_d = S_FIRST;
                    end
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mism = '0;
        for (int i = 0; i < TT_W; i++) begin
            mism = mism + CNT_W'(tt_q[i] ^ exp_q[i]);
        end
    end

    assign bus.fn_in        = idx_q;
    assign bus.busy         = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.tt           = tt_q;
    assign bus.tt_valid     = valid_q;
    assign bus.pass         = valid_q && (tt_q == exp_q);
    assign bus.mismatch_cnt = valid_q ? mism : '0;
    assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_bool_func_sweep_ctrl.sv
// Directed bench: one sequencer with the default settle time driving (a&~b)|c, and one
// with no settle time driving a^b^c.
module tb_bool_func_sweep_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bool_func_sweep_ctrl_if #(.N_IN(3), .CNT_W(4)) if0 ();
    bool_func_sweep_ctrl_if #(.N_IN(3), .CNT_W(4)) if1 ();

    assign if0.fn_out = (if0.fn_in[2] & ~if0.fn_in[1]) | if0.fn_in[0];
    assign if1.fn_out = ^if1.fn_in;

    bool_func_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(2), .CNT_W(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    bool_func_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(0), .CNT_W(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle0(input string tag);
        chk({tag, "_state"}, 32'(if0.state_dbg), 0);
        chk({tag, "_fn_in"}, 32'(if0.fn_in), 0);
        chk({tag, "_busy"}, 32'(if0.busy), 0);
        chk({tag, "_done"}, 32'(if0.done), 0);
    endtask

    task automatic chk_reset0(input string tag);
        chk_idle0(tag);
        chk({tag, "_tt"}, 32'(if0.tt), 0);
        chk({tag, "_tt_valid"}, 32'(if0.tt_valid), 0);
        chk({tag, "_pass"}, 32'(if0.pass), 0);
        chk({tag, "_mism"}, 32'(if0.mismatch_cnt), 0);
    endtask

    // Pulses start for one edge; returns in cycle 1 of the sweep.
    task automatic start0(input logic [7:0] e);
        if0.exp_tt = e;
        if0.start  = 1'b1;
        tick();
        if0.start  = 1'b0;
    endtask

    // Returns the sweep cycle in which done is seen, bounded.
    task automatic wait_done0(output int cyc);
        cyc = 1;
        while (!if0.done && cyc < 80) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int nd;
        int first_d;
        int second_d;
        rst = 1'b1;
        if0.start = 1'b0; if0.abort = 1'b0; if0.exp_tt = 8'h00;
        if1.start = 1'b0; if1.abort = 1'b0; if1.exp_tt = 8'h00;
        tick();
        tick();
        chk_reset0("rst");
        chk("rst_dut1_state", 32'(if1.state_dbg), 0);
        rst = 1'b0;
        tick();
        chk_reset0("post_rst");

        // 1: full sweep with 3-cycle vectors, expected table matches
        start0(8'hBA);
        for (int c = 1; c <= 25; c++) begin
            chk($sformatf("t1_fn_in_c%0d", c), 32'(if0.fn_in), (c <= 24) ? (c - 1) / 3 : 7);
            chk($sformatf("t1_done_c%0d", c), 32'(if0.done), (c == 25) ? 1 : 0);
            chk($sformatf("t1_busy_c%0d", c), 32'(if0.busy), (c <= 24) ? 1 : 0);
            tick();
        end
        chk_idle0("t1_after");
        chk("t1_tt", 32'(if0.tt), 32'h0BA);
        chk("t1_tt_valid", 32'(if0.tt_valid), 1);
        chk("t1_pass", 32'(if0.pass), 1);
        chk("t1_mism", 32'(if0.mismatch_cnt), 0);

        // 2: same function, wrong expected table (BA ^ B5 = 0F)
        start0(8'hB5);
        wait_done0(cyc);
        chk("t2_done_cycle", 32'(cyc), 25);
        tick();
        chk("t2_tt", 32'(if0.tt), 32'h0BA);
        chk("t2_pass", 32'(if0.pass), 0);
        chk("t2_mism", 32'(if0.mismatch_cnt), 4);

        // 3: zero settle time, parity function
        if1.exp_tt = 8'h96;
        if1.start  = 1'b1;
        tick();
        if1.start  = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) chk($sformatf("t3_fn_in_c%0d", c), 32'(if1.fn_in), c - 1);
            chk($sformatf("t3_done_c%0d", c), 32'(if1.done), (c == 9) ? 1 : 0);
            tick();
        end
        chk("t3_state", 32'(if1.state_dbg), 0);
        chk("t3_tt", 32'(if1.tt), 32'h096);
        chk("t3_pass", 32'(if1.pass), 1);
        chk("t3_mism", 32'(if1.mismatch_cnt), 0);

        // 4: abort in cycle 10, then a clean sweep
        start0(8'hBA);
        repeat (9) tick();
        if0.abort = 1'b1;
        tick();
        if0.abort = 1'b0;
        chk_idle0("t4_abort");
        chk("t4_tt_valid", 32'(if0.tt_valid), 0);
        chk("t4_pass", 32'(if0.pass), 0);
        chk("t4_mism", 32'(if0.mismatch_cnt), 0);
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            if (if0.done) nd++;
            tick();
        end
        chk("t4_no_done", 32'(nd), 0);
        start0(8'hBA);
        wait_done0(cyc);
        chk("t4_restart_done_cycle", 32'(cyc), 25);
        tick();
        chk("t4_restart_pass", 32'(if0.pass), 1);

        // 5: start during sweep and on DONE, exp_tt change mid-sweep, start+abort in IDLE
        start0(8'hBA);
        nd = 0;
        for (int c = 1; c <= 40; c++) begin
            if (if0.done) nd++;
            if (c == 25) chk("t5_done_c25", 32'(if0.done), 1);
            if0.start = (c == 5 || c == 25);
            if (c == 3) if0.exp_tt = 8'h00;
            tick();
        end
        if0.start = 1'b0;
        chk("t5_done_count", 32'(nd), 1);
        chk_idle0("t5_idle");
        chk("t5_pass", 32'(if0.pass), 1);
        chk("t5_mism", 32'(if0.mismatch_cnt), 0);
        if0.exp_tt = 8'hBA;
        if0.start = 1'b1;
        if0.abort = 1'b1;
        tick();
        if0.start = 1'b0;
        if0.abort = 1'b0;
        chk_idle0("t5_start_abort");
        tick();
        chk("t5_sa_state_later", 32'(if0.state_dbg), 0);
        chk("t5_sa_tt_valid", 32'(if0.tt_valid), 1);

        // 6: reset mid-sweep in cycle 12, then a full sweep
        start0(8'hBA);
        repeat (11) tick();
        chk("t6_busy_c12", 32'(if0.busy), 1);
        rst = 1'b1;
        tick();
        chk_reset0("t6_rst");
        rst = 1'b0;
        tick();
        start0(8'hBA);
        wait_done0(cyc);
        chk("t6_done_cycle", 32'(cyc), 25);
        tick();
        chk("t6_tt", 32'(if0.tt), 32'h0BA);
        chk("t6_pass", 32'(if0.pass), 1);

        // 7: start held high runs back-to-back sweeps
        if0.start = 1'b1;
        tick();
        first_d = 0;
        second_d = 0;
        for (int c = 1; c <= 60; c++) begin
            if (if0.done && first_d == 0) first_d = c;
            else if (if0.done && second_d == 0) second_d = c;
            tick();
        end
        if0.start = 1'b0;
        chk("t7_first_done", 32'(first_d), 25);
        chk("t7_second_done", 32'(second_d), 51);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
